mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
// Responder side of the controller strobe interface: turns the controller's enables (rom/ram ena/read/write,
// PC_en, pc_in, ad_sel, fetch) into memory traffic. Owns PC, instruction register (drives ins back to
// the controller), operand address register and the data RAM. Registers read data for the register file.
// Checks strobe legality and flags protocol errors.
// PARAMETERS
// AW     8   address width of PC, operand register and RAM (RAM depth 2**AW)
// DW     8   data/instruction byte width; ins = ir[DW-1:DW-4]
// PARAMETERS are static; DW >= 8 required.
// PORTS
// clk        in   1    system clock, all state on posedge
// rst        in   1    asynchronous active-low reset
// rom_ena    in   1    ROM enable from controller
// rom_read   in   1    ROM read strobe
// ram_ena    in   1    RAM enable
// ram_read   in   1    RAM read strobe
// ram_write  in   1    RAM write strobe
// ad_sel     in   1    address select: 1 = operand register, 0 = PC
// PC_en      in   1    PC update enable
// pc_in      in   1    with PC_en: load PC from ROM data (jump) instead of increment
// fetch      in   2    01 = byte fetch, 10 = operand fetch, 00/11 = none
// rom_data   in   DW   ROM read data (combinational ROM, valid same cycle as rom_addr)
// wr_data    in   DW   store data from register file
// err_clr    in   1    clears sticky error flags
// rom_addr   out  AW   ROM address = ad_sel ? opnd : pc (combinational)
// ins        out  4    opcode to controller
// pc         out  AW   program counter
// rd_data    out  DW   registered load data to register file
// rd_valid   out  1    one-cycle pulse: rd_data updated this cycle
// err        out  3    sticky: [0] ram_read&ram_write, [1] rom&ram both reading, [2] ram_write with ad_sel=0
// BEHAVIOUR
// - Reset (rst=0, async): pc=0, ir=0 (ins=NOP), opnd=0, rd_data=0, rd_valid=0, err=0. RAM contents not reset.
// - rd "rom_rd" = rom_ena&rom_read; "ram_rd" = ram_ena&ram_read; "ram_wr" = ram_ena&ram_write.
// - IR load: fetch==01 & rom_rd & !ad_sel & !pc_in -> ir<=rom_data at edge; ins reflects next cycle.
// - Operand load: fetch==10 & rom_rd -> opnd<=rom_data[AW-1:0]; opnd holds otherwise.
// - PC: PC_en&pc_in&rom_rd -> pc<=rom_data[AW-1:0]; PC_en&!pc_in -> pc<=pc+1, wraps 2**AW-1 -> 0;
//   PC_en&pc_in without rom_rd -> pc holds, err unaffected. Load has priority over increment.
// - Data load (fetch==01 & ad_sel): rom_rd -> rd_data<=rom_data; else ram_rd -> rd_data<=mem[opnd];
//   rd_valid=1 the following cycle only (latency 1). ram_rd with fetch!=01 also updates rd_data/rd_valid.
// - RAM write: ram_wr & ad_sel & !ram_read -> mem[opnd]<=wr_data at edge.
// - Read of an address written same cycle returns OLD data (read-before-write).
// - Errors (set at edge, sticky until err_clr): err[0] ram_read&ram_write&ram_ena -> write suppressed, read
//   performed; err[1] rom_rd&ram_rd -> ROM wins; err[2] ram_wr & !ad_sel -> write suppressed.
// - err_clr and a new error same cycle: new error wins (bit set).
// - Idle/halt (all strobes 0): every register holds; rd_valid=0.
// - Reset mid-operation: any in-flight write dropped, rd_valid forced 0 immediately.
// STRUCTURE
// - cpu8_pkg: opcode constants (NOP..HLT, 4-bit), controller state codes, FETCH_NONE=00/FETCH_BYTE=01/
//   FETCH_OPND=10, err bit indices. Shared with controller.
// - Sub-module ram_array #(AW,DW): single-port, sync write, sync read, no reset.
// - Top: PC/IR/opnd regs, address mux, error logic.
// TESTING
// - Reset, then fetch=01,rom_rd,rom_data=8'h25 -> ins=4'h2 next cycle, pc=0, rd_valid=0.
// - pc=8'hFF, PC_en=1,pc_in=0 -> pc=8'h00; PC_en=1,pc_in=1,rom_rd,rom_data=8'h40 -> pc=8'h40.
// - fetch=10,rom_data=8'h1C; then ram_wr,ad_sel,wr_data=8'hA5; then ram_rd,ad_sel,fetch=01 ->
//   rd_data=8'hA5, rd_valid pulse 1 cycle, rom_addr=8'h1C while ad_sel=1.
// - ram_ena,ram_read,ram_write,ad_sel on addr 8'h1C -> err[0]=1, mem[8'h1C] still 8'hA5; err_clr -> err=0.
// - ram_wr with ad_sel=0 -> err[2]=1, no RAM change; rom_rd&ram_rd with fetch=01,ad_sel -> err[1]=1, rd_data=rom_data.
// - Assert rst low during ram_wr cycle -> write dropped, all outputs at reset values same cycle.

Source files
------------

// File: rtl/cpu8_pkg.sv
// cpu8_pkg: definitions shared by the 8-bit CPU controller and the memory responder.
// Contents: 4-bit opcode constants, controller state codes, fetch-mode
// encodings and the bit positions of the responder's sticky error flags.
package cpu8_pkg;

  // Opcodes carried in the top nibble of the instruction byte.
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDO = 4'h1,
    OP_LDA = 4'h2,
    OP_LDR = 4'h3,
    OP_PRE = 4'h4,
    OP_STO = 4'h5,
    OP_ADD = 4'h6,
    OP_SHL = 4'h7,
    OP_SHR = 4'h8,
    OP_SUB = 4'h9,
    OP_AND = 4'hA,
    OP_OR  = 4'hB,
    OP_JMP = 4'hC,
    OP_JZ  = 4'hD,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Controller state codes.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_OPND   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEM    = 3'd5,
    ST_WBACK  = 3'd6,
    ST_HALT   = 3'd7
  } ctrl_state_e;

  // Fetch-mode encodings on the fetch strobe pair.
  localparam logic [1:0] FETCH_NONE = 2'b00;
  localparam logic [1:0] FETCH_BYTE = 2'b01;
  localparam logic [1:0] FETCH_OPND = 2'b10;

  // Sticky error flag bit positions.
  localparam int ERR_RW_BOTH = 0;  // ram_read and ram_write together
  localparam int ERR_DUAL_RD = 1;  // ROM and RAM reading together
  localparam int ERR_WR_PC   = 2;  // RAM write addressed through the PC

endpackage

// File: rtl/ram_array.sv
// ram_array: single-port data RAM, synchronous write and synchronous read,
// no reset on the storage or the read register.
// Ports:
//   clk   - clock
//   we    - write enable, mem[addr] <= wdata at the edge
//   re    - read enable, rdata <= mem[addr] at the edge (old data when
//           the same address is written in the same cycle)
//   addr  - shared read/write address
//   wdata - write data
//   rdata - registered read data, holds when re is low
module ram_array #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: responder side of the controller strobe interface. Owns the
// program counter, instruction register, operand address register and data
// RAM; turns controller strobes into ROM/RAM traffic and flags illegal strobe
// combinations in sticky error bits.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   rom_ena, rom_read        - ROM read request (both high = ROM read)
//   ram_ena, ram_read/write  - RAM read / write requests
//   ad_sel                   - address source: 1 = operand register, 0 = PC
//   PC_en, pc_in             - PC update: increment, or jump-load from ROM data
//   fetch                    - 01 byte fetch, 10 operand fetch, else none
//   rom_data, wr_data        - ROM read data, store data from register file
//   err_clr                  - clears sticky error flags
//   rom_addr                 - combinational ROM address
//   ins, pc                  - opcode to controller, program counter
//   rd_data, rd_valid        - load data and its one-cycle valid pulse
//   err                      - sticky protocol error flags
// Handshake: there is no back-pressure. A load strobed in cycle N produces
// rd_valid=1 with the new rd_data in cycle N+1 only; rd_data holds afterwards.
module mem_responder
  import cpu8_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rom_ena,
  input  logic          rom_read,
  input  logic          ram_ena,
  input  logic          ram_read,
  input  logic          ram_write,
  input  logic          ad_sel,
  input  logic          PC_en,
  input  logic          pc_in,
  input  logic [1:0]    fetch,
  input  logic [DW-1:0] rom_data,
  input  logic [DW-1:0] wr_data,
  input  logic          err_clr,
  output logic [AW-1:0] rom_addr,
  output logic [3:0]    ins,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [2:0]    err
);

  logic          rom_rd, ram_rd, ram_wr;
  logic          ir_load, opnd_load, rom_data_load, ram_data_load;
  logic          ram_we, ram_re;
  logic [2:0]    err_new;
  logic [3:0]    ir;
  logic [AW-1:0] opnd;
  logic [DW-1:0] rom_q;
  logic [DW-1:0] ram_q;
  logic          src_ram;

  assign rom_rd = rom_ena & rom_read;
  assign ram_rd = ram_ena & ram_read;
  assign ram_wr = ram_ena & ram_write;

  assign ir_load       = (fetch == FETCH_BYTE) & rom_rd & ~ad_sel & ~pc_in;
  assign opnd_load     = (fetch == FETCH_OPND) & rom_rd;
  assign rom_data_load = (fetch == FETCH_BYTE) & ad_sel & rom_rd;
  // ROM wins a simultaneous ROM/RAM read, so the RAM read is dropped then.
  assign ram_data_load = ram_rd & ~rom_rd;

  // Gating with rst drops any write/read strobed in a cycle whose edge
  // lands while reset is asserted.
  assign ram_we = ram_wr & ad_sel & ~ram_read & rst;
  assign ram_re = ram_data_load & rst;

  always_comb begin
    err_new              = '0;
    err_new[ERR_RW_BOTH] = ram_ena & ram_read & ram_write;
    err_new[ERR_DUAL_RD] = rom_rd & ram_rd;
    err_new[ERR_WR_PC]   = ram_wr & ~ad_sel;
  end

  assign rom_addr = ad_sel ? opnd : pc;
  assign ins      = ir;
  // RAM read data comes straight from the RAM's own read register; the
  // source flag picks whichever load happened last.
  assign rd_data  = src_ram ? ram_q : rom_q;

  ram_array #(.AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (opnd),
    .wdata (wr_data),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= '0;
      ir       <= OP_NOP;
      opnd     <= '0;
      rom_q    <= '0;
      src_ram  <= 1'b0;
      rd_valid <= 1'b0;
      err      <= '0;
    end else begin
      if (PC_en && pc_in && rom_rd) pc <= rom_data[AW-1:0];
      else if (PC_en && !pc_in)     pc <= pc + AW'(1);

      if (ir_load)   ir   <= rom_data[DW-1:DW-4];
      if (opnd_load) opnd <= rom_data[AW-1:0];

      if (rom_data_load) begin
        rom_q   <= rom_data;
        src_ram <= 1'b0;
      end else if (ram_data_load) begin
        src_ram <= 1'b1;
      end
      rd_valid <= rom_data_load | ram_data_load;

      // A new error in the same cycle as err_clr stays set.
      err <= (err & ~{3{err_clr}}) | err_new;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed scenarios plus randomized strobes,
// checked against a transaction-level model (arrays and plain arithmetic).
// Load data is pushed to a scoreboard queue; a separate monitor pops it when
// the DUT pulses rd_valid.
module tb_mem_responder;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_ena, rom_read, ram_ena, ram_read, ram_write;
  logic          ad_sel, PC_en, pc_in, err_clr;
  logic [1:0]    fetch;
  logic [DW-1:0] rom_data, wr_data;
  logic [AW-1:0] rom_addr;
  logic [3:0]    ins;
  logic [AW-1:0] pc;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [2:0]    err;

  mem_responder #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .rom_ena(rom_ena), .rom_read(rom_read),
    .ram_ena(ram_ena), .ram_read(ram_read), .ram_write(ram_write),
    .ad_sel(ad_sel), .PC_en(PC_en), .pc_in(pc_in), .fetch(fetch),
    .rom_data(rom_data), .wr_data(wr_data), .err_clr(err_clr),
    .rom_addr(rom_addr), .ins(ins), .pc(pc),
    .rd_data(rd_data), .rd_valid(rd_valid), .err(err)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- counters and reference model ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem_m [256];
  int            pc_m;
  logic [7:0]    ir_m;
  logic [7:0]    opnd_m;
  logic [2:0]    err_m;
  logic          exp_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pc_m = 0; ir_m = 8'h00; opnd_m = 8'h00; err_m = 3'b000;
    exp_valid = 1'b0;
    exp_q.delete();
  endtask

  // One clock of the protocol rules, applied to the strobes currently driven.
  task automatic model_step();
    bit rom_rd, ram_rd, ram_wr;
    logic [2:0] new_err;
    rom_rd = rom_ena && rom_read;
    ram_rd = ram_ena && ram_read;
    ram_wr = ram_ena && ram_write;
    exp_valid = 1'b0;
    if (fetch == 2'b01 && ad_sel && rom_rd) begin
      exp_valid = 1'b1;
      exp_q.push_back(rom_data);
    end else if (ram_rd && !rom_rd) begin
      exp_valid = 1'b1;
      exp_q.push_back(mem_m[opnd_m]);  // read sees memory before this cycle's write
    end
    if (ram_wr && ad_sel && !ram_read) mem_m[opnd_m] = wr_data;
    if (fetch == 2'b01 && rom_rd && !ad_sel && !pc_in) ir_m = rom_data;
    if (fetch == 2'b10 && rom_rd) opnd_m = rom_data;
    if (PC_en && pc_in && rom_rd) pc_m = rom_data;
    else if (PC_en && !pc_in) pc_m = (pc_m + 1) % 256;
    new_err = {ram_wr && !ad_sel, rom_rd && ram_rd, ram_ena && ram_read && ram_write};
    err_m = err_clr ? new_err : (err_m | new_err);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rom_ena = 0; rom_read = 0; ram_ena = 0; ram_read = 0; ram_write = 0;
    ad_sel = 0; PC_en = 0; pc_in = 0; err_clr = 0; fetch = 2'b00;
    rom_data = '0; wr_data = '0;
  endtask

  // Applies the current strobes for one edge, then checks state at the negedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("pc", pc, pc_m[7:0]);
    check("ins", ins, ir_m[7:4]);
    check("err", err, err_m);
    check("rom_addr", rom_addr, ad_sel ? opnd_m : pc_m[7:0]);
  endtask

  task automatic load_opnd(input logic [7:0] a);
    idle(); fetch = 2'b10; rom_ena = 1; rom_read = 1; rom_data = a; tick();
  endtask

  task automatic ram_store(input logic [7:0] d);
    idle(); ram_ena = 1; ram_write = 1; ad_sel = 1; wr_data = d; tick();
  endtask

  task automatic ram_load();
    idle(); ram_ena = 1; ram_read = 1; ad_sel = 1; fetch = 2'b01; tick();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #2;
    if (rst === 1'b1) begin
      check("rd_valid", rd_valid, exp_valid);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          check("rd_data", rd_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_ins", ins, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_err", err, 0);
    rst = 1'b1;

    // Byte fetch loads IR; no data load.
    idle(); fetch = 2'b01; rom_ena = 1; rom_read = 1; rom_data = 8'h25; tick();
    check("ins_after_fetch", ins, 4'h2);
    check("pc_after_fetch", pc, 0);
    check("rd_valid_after_fetch", rd_valid, 0);

    // PC jump to FF, wrap on increment, then jump to 40.
    idle(); PC_en = 1; pc_in = 1; rom_ena = 1; rom_read = 1; rom_data = 8'hFF; tick();
    check("pc_jump_ff", pc, 8'hFF);
    idle(); PC_en = 1; tick();
    check("pc_wrap", pc, 8'h00);
    idle(); PC_en = 1; pc_in = 1; rom_ena = 1; rom_read = 1; rom_data = 8'h40; tick();
    check("pc_jump_40", pc, 8'h40);
    // Jump request without ROM read holds PC.
    idle(); PC_en = 1; pc_in = 1; tick();
    check("pc_jump_hold", pc, 8'h40);

    // Fill the whole RAM so every later read has a known value.
    for (int a = 0; a < 256; a++) begin
      load_opnd(8'(a));
      ram_store(8'($urandom_range(0, 255)));
    end

    // Operand fetch, store, load back.
    load_opnd(8'h1C);
    ram_store(8'hA5);
    ram_load();
    check("rom_addr_opnd", rom_addr, 8'h1C);
    idle(); tick();

    // read+write together: err[0], write suppressed, read performed.
    idle(); ram_ena = 1; ram_read = 1; ram_write = 1; ad_sel = 1; wr_data = 8'h11; tick();
    check("err0_set", err, 3'b001);
    ram_load();
    idle(); err_clr = 1; tick();
    check("err_cleared", err, 3'b000);

    // Write through PC address: err[2], no RAM change.
    idle(); ram_ena = 1; ram_write = 1; ad_sel = 0; wr_data = 8'h77; tick();
    check("err2_set", err, 3'b100);
    ram_load();
    // Clear and new error in the same cycle: new error wins.
    idle(); err_clr = 1; ram_ena = 1; ram_write = 1; tick();
    check("err_clr_vs_new", err, 3'b100);
    idle(); err_clr = 1; tick();

    // ROM and RAM both read: err[1], ROM data wins.
    idle(); fetch = 2'b01; ad_sel = 1; rom_ena = 1; rom_read = 1; ram_ena = 1; ram_read = 1;
    rom_data = 8'h5A; tick();
    check("err1_set", err, 3'b010);
    idle(); err_clr = 1; tick();

    // Reset asserted during a RAM write cycle.
    idle(); ram_load();
    idle(); ram_ena = 1; ram_write = 1; ad_sel = 1; wr_data = 8'h3C;
    #2 rst = 1'b0;
    #1;
    check("midrst_pc", pc, 0);
    check("midrst_ins", ins, 0);
    check("midrst_rd_data", rd_data, 0);
    check("midrst_rd_valid", rd_valid, 0);
    check("midrst_err", err, 0);
    check("midrst_rom_addr", rom_addr, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b1;
    load_opnd(8'h1C);
    ram_load();  // must still return A5
    idle(); tick();

    // Randomized strobes.
    for (int i = 0; i < 600; i++) begin
      idle();
      rom_ena   = 1'($urandom_range(0, 1));
      rom_read  = 1'($urandom_range(0, 1));
      ram_ena   = 1'($urandom_range(0, 1));
      ram_read  = 1'($urandom_range(0, 1));
      ram_write = 1'($urandom_range(0, 1));
      ad_sel    = 1'($urandom_range(0, 1));
      PC_en     = 1'($urandom_range(0, 1));
      pc_in     = 1'($urandom_range(0, 1));
      fetch     = 2'($urandom_range(0, 3));
      err_clr   = ($urandom_range(0, 3) == 0);
      rom_data  = 8'($urandom_range(0, 255));
      wr_data   = 8'($urandom_range(0, 255));
      tick();
    end

    idle(); tick();
    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
